// File: rtl/systolic_pkg.sv
// Shared types and width-generic arithmetic helpers for the systolic array processing elements.
// Helpers work on MAX_W-bit vectors with an explicit active width so one body serves every instance.
package systolic_pkg;

  localparam int unsigned DEFAULT_DATA_W = 8;
  localparam int unsigned DEFAULT_ACC_W  = 32;
  localparam int unsigned MAX_W          = 128;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } pe_res_state_t;

  function automatic logic [MAX_W-1:0] lo_mask(input int unsigned w);
    return (MAX_W'(1) << w) - MAX_W'(1);
  endfunction

  function automatic logic bit_at(input logic [MAX_W-1:0] v, input int unsigned idx);
    return |(v & (MAX_W'(1) << idx));
  endfunction

  // Sign- or zero-extend the low from_w bits of v to MAX_W bits.
  function automatic logic [MAX_W-1:0] extend(input logic [MAX_W-1:0] v,
                                              input int unsigned from_w,
                                              input logic is_signed);
    logic [MAX_W-1:0] m;
    logic             sgn;
    m   = lo_mask(from_w);
    sgn = bit_at(v, from_w - 1);
    return (v & m) | ((is_signed & sgn) ? ~m : '0);
  endfunction

  function automatic logic [MAX_W-1:0] add_full(input logic [MAX_W-1:0] a,
                                                input logic [MAX_W-1:0] b,
                                                input int unsigned w,
                                                input logic is_signed);
    logic [MAX_W-1:0] m;
    m = lo_mask(w);
    return extend(a & m, w, is_signed) + extend(b & m, w, is_signed);
  endfunction

  // The w+1 bit exact sum leaves the w-bit range.
  function automatic logic add_ovf(input logic [MAX_W-1:0] a,
                                   input logic [MAX_W-1:0] b,
                                   input int unsigned w,
                                   input logic is_signed);
    logic [MAX_W-1:0] full;
    full = add_full(a, b, w, is_signed);
    return is_signed ? (bit_at(full, w) ^ bit_at(full, w - 1)) : bit_at(full, w);
  endfunction

  function automatic logic [MAX_W-1:0] sat_add(input logic [MAX_W-1:0] a,
                                               input logic [MAX_W-1:0] b,
                                               input int unsigned w,
                                               input logic is_signed,
                                               input logic saturate);
    logic [MAX_W-1:0] m;
    logic [MAX_W-1:0] full;
    logic [MAX_W-1:0] smax;
    logic [MAX_W-1:0] smin;
    logic             neg;
    m    = lo_mask(w);
    full = add_full(a, b, w, is_signed);
    neg  = is_signed & bit_at(full, w);
    smax = is_signed ? (m >> 1) : m;
    smin = is_signed ? (m & ~(m >> 1)) : '0;
    if (saturate && add_ovf(a, b, w, is_signed)) begin
      return neg ? smin : smax;
    end
    return full & m;
  endfunction

endpackage

// File: rtl/pe_sat_acc.sv
// Combinational multiply, extend, accumulate with overflow detect and optional clamp.
module pe_sat_acc
  import systolic_pkg::*;
#(
  parameter int unsigned DATA_W = DEFAULT_DATA_W,
  parameter int unsigned ACC_W  = DEFAULT_ACC_W,
  parameter bit          SIGNED = 1'b0,
  parameter bit          SAT    = 1'b1
) (
  input  logic [ACC_W-1:0]  i_acc,
  input  logic [DATA_W-1:0] i_a,
  input  logic [DATA_W-1:0] i_b,
  input  logic              i_fire,
  output logic [ACC_W-1:0]  o_sum_c,
  output logic              o_ovf_c
);

  localparam int unsigned PROD_W = 2 * DATA_W;

  logic [PROD_W-1:0] w_a_ext;
  logic [PROD_W-1:0] w_b_ext;
  logic [PROD_W-1:0] w_prod;
  logic [ACC_W-1:0]  w_addend;

  if (ACC_W + 1 > MAX_W) begin : g_bad_width
    $error("ACC_W exceeds the helper vector width");
  end

  // Low PROD_W bits of the product of extended operands are exact for both signednesses.
  assign w_a_ext  = PROD_W'(extend(MAX_W'(i_a), DATA_W, SIGNED));
  assign w_b_ext  = PROD_W'(extend(MAX_W'(i_b), DATA_W, SIGNED));
  assign w_prod   = w_a_ext * w_b_ext;
  assign w_addend = i_fire ? ACC_W'(extend(MAX_W'(w_prod), PROD_W, SIGNED)) : '0;

  assign o_sum_c = ACC_W'(sat_add(MAX_W'(i_acc), MAX_W'(w_addend), ACC_W, SIGNED, SAT));
  assign o_ovf_c = add_ovf(MAX_W'(i_acc), MAX_W'(w_addend), ACC_W, SIGNED);

endmodule

// File: rtl/systolic_pe_mac.sv
// Systolic processing element: operand forwarding, MAC accumulator and a drain/clear
// path delivering results through a valid/ready result register.
module systolic_pe_mac
  import systolic_pkg::*;
#(
  parameter int unsigned DATA_W = DEFAULT_DATA_W,
  parameter int unsigned ACC_W  = DEFAULT_ACC_W,
  parameter bit          SIGNED = 1'b0,
  parameter bit          SAT    = 1'b1
) (
  input  logic              i_clk,
  input  logic              i_arst_n,
  input  logic [DATA_W-1:0] i_a,
  input  logic              i_a_valid,
  input  logic [DATA_W-1:0] i_b,
  input  logic              i_b_valid,
  output logic [DATA_W-1:0] o_a,
  output logic              o_a_valid,
  output logic [DATA_W-1:0] o_b,
  output logic              o_b_valid,
  input  logic              i_clear,
  input  logic              i_drain,
  output logic              o_drain_ready,
  output logic [ACC_W-1:0]  o_acc,
  output logic              o_acc_valid,
  input  logic              i_acc_ready,
  output logic              o_ovf
);

  if (ACC_W < 2 * DATA_W) begin : g_bad_acc_w
    $error("ACC_W must be at least 2*DATA_W");
  end

  logic [DATA_W-1:0] r_a;
  logic              r_a_valid;
  logic [DATA_W-1:0] r_b;
  logic              r_b_valid;
  logic [ACC_W-1:0]  r_acc;
  logic [ACC_W-1:0]  r_res;
  logic              r_ovf;
  pe_res_state_t     r_state;

  logic              w_fire;
  logic              w_drain_ready;
  logic              w_drain_acc;
  logic [ACC_W-1:0]  w_sum;
  logic              w_sum_ovf;

  assign w_fire = i_a_valid & i_b_valid;

  // Ready is held low while in reset so every output reads 0 during reset.
  assign w_drain_ready = i_arst_n & ((r_state == EMPTY) | i_acc_ready);
  assign w_drain_acc   = i_drain & w_drain_ready & ~i_clear;

  pe_sat_acc #(
    .DATA_W (DATA_W),
    .ACC_W  (ACC_W),
    .SIGNED (SIGNED),
    .SAT    (SAT)
  ) u_sat_acc (
    .i_acc   (r_acc),
    .i_a     (i_a),
    .i_b     (i_b),
    .i_fire  (w_fire),
    .o_sum_c (w_sum),
    .o_ovf_c (w_sum_ovf)
  );

  always_ff @(posedge i_clk or negedge i_arst_n) begin
    if (!i_arst_n) begin
      r_a       <= '0;
      r_a_valid <= 1'b0;
      r_b       <= '0;
      r_b_valid <= 1'b0;
      r_acc     <= '0;
      r_res     <= '0;
      r_ovf     <= 1'b0;
      r_state   <= EMPTY;
    end else begin
      r_a_valid <= i_a_valid;
      r_b_valid <= i_b_valid;
      if (i_a_valid) r_a <= i_a;
      if (i_b_valid) r_b <= i_b;

      // Clear discards a same-cycle product; an accepted drain carries it into the result.
      if (i_clear || w_drain_acc) begin
        r_acc <= '0;
        r_ovf <= 1'b0;
      end else begin
        r_acc <= w_sum;
        r_ovf <= r_ovf | w_sum_ovf;
      end

      case (r_state)
        EMPTY: begin
          if (w_drain_acc) begin
            r_res   <= w_sum;
            r_state <= FULL;
          end
        end
        FULL: begin
          if (w_drain_acc) begin
            r_res <= w_sum;
          end else if (i_acc_ready) begin
            r_state <= EMPTY;
          end
        end
        default: r_state <= EMPTY;
      endcase
    end
  end

  assign o_a           = r_a;
  assign o_a_valid     = r_a_valid;
  assign o_b           = r_b;
  assign o_b_valid     = r_b_valid;
  assign o_acc         = r_res;
  assign o_acc_valid   = (r_state == FULL);
  assign o_ovf         = r_ovf;
  assign o_drain_ready = w_drain_ready;

endmodule

// File: tb/tb_systolic_pe_mac.sv
// Bench for systolic_pe_mac: four parameterisations share one stimulus stream and are
// checked every cycle against an integer-arithmetic reference model.
module tb_systolic_pe_mac;

  localparam int N = 4;
  localparam int CW  [N] = '{32, 32, 16, 16};
  localparam bit CSG [N] = '{1'b0, 1'b1, 1'b0, 1'b0};
  localparam bit CST [N] = '{1'b1, 1'b1, 1'b1, 1'b0};

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] a, b;
  logic       av, bv, clear, drain, acc_ready;

  logic [N-1:0][7:0] oa, ob;
  logic [N-1:0]      oav, obv, dr, accv, ovf;
  logic [1:0][31:0]  acc32;
  logic [1:0][15:0]  acc16;

  int errors = 0;
  int checks = 0;

  longint     m_acc [N];
  longint     m_res [N];
  bit         m_vld [N];
  bit         m_ovf [N];
  logic [7:0] m_oa, m_ob;
  bit         m_oav, m_obv;

  always #5 clk = ~clk;

  systolic_pe_mac #(.DATA_W(8), .ACC_W(32), .SIGNED(1'b0), .SAT(1'b1)) u_dut0 (
    .i_clk(clk), .i_arst_n(rst_n), .i_a(a), .i_a_valid(av), .i_b(b), .i_b_valid(bv),
    .o_a(oa[0]), .o_a_valid(oav[0]), .o_b(ob[0]), .o_b_valid(obv[0]),
    .i_clear(clear), .i_drain(drain), .o_drain_ready(dr[0]), .o_acc(acc32[0]),
    .o_acc_valid(accv[0]), .i_acc_ready(acc_ready), .o_ovf(ovf[0]));

  systolic_pe_mac #(.DATA_W(8), .ACC_W(32), .SIGNED(1'b1), .SAT(1'b1)) u_dut1 (
    .i_clk(clk), .i_arst_n(rst_n), .i_a(a), .i_a_valid(av), .i_b(b), .i_b_valid(bv),
    .o_a(oa[1]), .o_a_valid(oav[1]), .o_b(ob[1]), .o_b_valid(obv[1]),
    .i_clear(clear), .i_drain(drain), .o_drain_ready(dr[1]), .o_acc(acc32[1]),
    .o_acc_valid(accv[1]), .i_acc_ready(acc_ready), .o_ovf(ovf[1]));

  systolic_pe_mac #(.DATA_W(8), .ACC_W(16), .SIGNED(1'b0), .SAT(1'b1)) u_dut2 (
    .i_clk(clk), .i_arst_n(rst_n), .i_a(a), .i_a_valid(av), .i_b(b), .i_b_valid(bv),
    .o_a(oa[2]), .o_a_valid(oav[2]), .o_b(ob[2]), .o_b_valid(obv[2]),
    .i_clear(clear), .i_drain(drain), .o_drain_ready(dr[2]), .o_acc(acc16[0]),
    .o_acc_valid(accv[2]), .i_acc_ready(acc_ready), .o_ovf(ovf[2]));

  systolic_pe_mac #(.DATA_W(8), .ACC_W(16), .SIGNED(1'b0), .SAT(1'b0)) u_dut3 (
    .i_clk(clk), .i_arst_n(rst_n), .i_a(a), .i_a_valid(av), .i_b(b), .i_b_valid(bv),
    .o_a(oa[3]), .o_a_valid(oav[3]), .o_b(ob[3]), .o_b_valid(obv[3]),
    .i_clear(clear), .i_drain(drain), .o_drain_ready(dr[3]), .o_acc(acc16[1]),
    .o_acc_valid(accv[3]), .i_acc_ready(acc_ready), .o_ovf(ovf[3]));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic longint opval(input logic [7:0] x, input bit sg);
    return sg ? longint'($signed(x)) : longint'({56'b0, x});
  endfunction

  function automatic logic [31:0] obs_acc(input int k);
    return (k < 2) ? acc32[k] : {16'b0, acc16[k-2]};
  endfunction

  function automatic logic [31:0] exp_acc(input int k);
    longint msk;
    msk = (longint'(1) << CW[k]) - 1;
    return 32'(m_res[k] & msk);
  endfunction

  task automatic model_reset();
    for (int k = 0; k < N; k++) begin
      m_acc[k] = 0; m_res[k] = 0; m_vld[k] = 0; m_ovf[k] = 0;
    end
    m_oa = '0; m_ob = '0; m_oav = 0; m_obv = 0;
  endtask

  // Exact integer sum, then range check, clamp or wrap, then the result handshake rules.
  task automatic model_step();
    bit fire, ov, ready, dacc;
    longint va, vb, exact, lo, hi, sumv, msk;
    fire = av & bv;
    for (int k = 0; k < N; k++) begin
      va    = opval(a, CSG[k]);
      vb    = opval(b, CSG[k]);
      exact = m_acc[k] + (fire ? va * vb : 0);
      msk   = (longint'(1) << CW[k]) - 1;
      lo    = CSG[k] ? -(longint'(1) << (CW[k] - 1)) : 0;
      hi    = CSG[k] ? (longint'(1) << (CW[k] - 1)) - 1 : msk;
      ov    = (exact < lo) || (exact > hi);
      if (!ov) sumv = exact;
      else if (CST[k]) sumv = (exact < lo) ? lo : hi;
      else begin
        sumv = exact & msk;
        if (CSG[k] && sumv > hi) sumv = sumv - (msk + 1);
      end
      ready = !m_vld[k] || acc_ready;
      dacc  = drain && ready && !clear;
      if (dacc) begin
        m_res[k] = sumv; m_vld[k] = 1; m_acc[k] = 0; m_ovf[k] = 0;
      end else begin
        if (m_vld[k] && acc_ready) m_vld[k] = 0;
        if (clear) begin
          m_acc[k] = 0; m_ovf[k] = 0;
        end else begin
          m_acc[k] = sumv; m_ovf[k] = m_ovf[k] | ov;
        end
      end
    end
    m_oav = av; m_obv = bv;
    if (av) m_oa = a;
    if (bv) m_ob = b;
  endtask

  task automatic check_all();
    for (int k = 0; k < N; k++) begin
      chk($sformatf("acc%0d", k), obs_acc(k), exp_acc(k));
      chk($sformatf("acc_valid%0d", k), 32'(accv[k]), 32'(m_vld[k]));
      chk($sformatf("ovf%0d", k), 32'(ovf[k]), 32'(m_ovf[k]));
      chk($sformatf("o_a%0d", k), 32'(oa[k]), 32'(m_oa));
      chk($sformatf("o_a_valid%0d", k), 32'(oav[k]), 32'(m_oav));
      chk($sformatf("o_b%0d", k), 32'(ob[k]), 32'(m_ob));
      chk($sformatf("o_b_valid%0d", k), 32'(obv[k]), 32'(m_obv));
    end
  endtask

  task automatic drive(input bit iav, input logic [7:0] ia, input bit ibv, input logic [7:0] ib,
                       input bit idr, input bit icl, input bit irdy);
    av = iav; a = ia; bv = ibv; b = ib; drain = idr; clear = icl; acc_ready = irdy;
  endtask

  // Called at a falling edge with inputs applied; returns at the next falling edge.
  task automatic tick();
    #1;
    for (int k = 0; k < N; k++)
      chk($sformatf("drain_ready%0d", k), 32'(dr[k]), 32'(rst_n && (!m_vld[k] || acc_ready)));
    model_step();
    @(posedge clk);
    #1;
    check_all();
    @(negedge clk);
  endtask

  initial begin
    logic [31:0] held;
    rst_n = 1'b0;
    drive(0, 8'd0, 0, 8'd0, 0, 0, 0);
    model_reset();
    #2;
    check_all();
    chk("reset_drain_ready", 32'(dr[0]), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Unsigned accumulate then drain without a fire
    for (int i = 0; i < 4; i++) begin
      drive(1, 8'd3, 1, 8'd5, 0, 0, 1);
      tick();
    end
    chk("t1_o_a", 32'(oa[0]), 32'd3);
    chk("t1_o_b", 32'(ob[0]), 32'd5);
    drive(0, 8'd0, 0, 8'd0, 1, 0, 1);
    tick();
    chk("t1_acc", obs_acc(0), 32'd60);
    chk("t1_valid", 32'(accv[0]), 32'd1);
    drive(0, 8'd0, 0, 8'd0, 0, 0, 1);
    tick();

    // Signed: drain on the same cycle as the second fire
    drive(1, 8'hFE, 1, 8'd7, 0, 0, 1);
    tick();
    drive(1, 8'd4, 1, 8'hFD, 1, 0, 0);
    tick();
    chk("t2_acc_signed", obs_acc(1), 32'hFFFF_FFE6);
    drive(0, 8'd0, 0, 8'd0, 1, 0, 1);
    tick();
    chk("t2_acc_zero_after", obs_acc(1), 32'd0);
    drive(0, 8'd0, 0, 8'd0, 0, 0, 1);
    tick();

    // 16-bit saturate vs wrap
    drive(0, 8'd0, 0, 8'd0, 0, 1, 1);
    tick();
    drive(1, 8'd255, 1, 8'd255, 0, 0, 1);
    tick();
    chk("t3_ovf_first", 32'(ovf[2]), 32'd0);
    tick();
    chk("t3_ovf_sat", 32'(ovf[2]), 32'd1);
    chk("t3_ovf_wrap", 32'(ovf[3]), 32'd1);
    drive(0, 8'd0, 0, 8'd0, 1, 0, 1);
    tick();
    chk("t3_acc_sat", obs_acc(2), 32'h0000_FFFF);
    chk("t3_acc_wrap", obs_acc(3), 32'h0000_FC02);
    chk("t3_ovf_cleared", 32'(ovf[2]), 32'd0);
    drive(0, 8'd0, 0, 8'd0, 0, 0, 1);
    tick();

    // Backpressure: drain held while the result is not consumed
    drive(1, 8'd2, 1, 8'd3, 1, 0, 0);
    tick();
    held = obs_acc(0);
    chk("t4_first", held, 32'd6);
    for (int i = 0; i < 5; i++) begin
      drive(1, 8'd1, 1, 8'd2, 1, 0, 0);
      tick();
      chk("t4_ready_low", 32'(dr[0]), 32'd0);
      chk("t4_hold", obs_acc(0), held);
    end
    drive(1, 8'd1, 1, 8'd2, 1, 0, 1);
    #1;
    chk("t4_ready_high", 32'(dr[0]), 32'd1);
    tick();
    chk("t4_new", obs_acc(0), 32'd12);
    chk("t4_valid_cont", 32'(accv[0]), 32'd1);
    drive(0, 8'd0, 0, 8'd0, 0, 0, 1);
    tick();

    // Clear beats drain and a same-cycle fire
    drive(1, 8'd255, 1, 8'd255, 0, 0, 1);
    tick();
    tick();
    drive(1, 8'd255, 1, 8'd255, 1, 1, 1);
    tick();
    chk("t5_no_result", 32'(accv[0]), 32'd0);
    chk("t5_ovf_clear", 32'(ovf[2]), 32'd0);
    drive(0, 8'd0, 0, 8'd0, 1, 0, 1);
    tick();
    chk("t5_acc_zero", obs_acc(2), 32'd0);
    drive(0, 8'd0, 0, 8'd0, 0, 0, 1);
    tick();

    // Invalid gaps on a
    for (int i = 0; i < 8; i++) begin
      drive((i % 2) == 0, 8'(i + 1), 1, 8'd2, 0, 0, 1);
      tick();
      if ((i % 2) == 1) chk("t6_a_hold", 32'(oa[0]), 32'(i));
    end
    drive(0, 8'd0, 0, 8'd0, 1, 0, 1);
    tick();
    chk("t6_gap_acc", obs_acc(0), 32'd32);

    // Randomised traffic
    for (int i = 0; i < 400; i++) begin
      drive($urandom_range(0, 9) < 7, 8'($urandom), $urandom_range(0, 9) < 7, 8'($urandom),
            $urandom_range(0, 9) < 2, $urandom_range(0, 19) == 0, $urandom_range(0, 1) == 1);
      tick();
    end

    // Asynchronous reset mid-stream
    drive(1, 8'd5, 1, 8'd6, 0, 0, 0);
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    check_all();
    chk("t6_reset_ready", 32'(dr[0]), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    drive(0, 8'd0, 0, 8'd0, 0, 0, 1);
    tick();
    drive(1, 8'd7, 1, 8'd9, 1, 0, 1);
    tick();
    chk("t6_post_reset", obs_acc(0), 32'd63);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
